// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging NUM_SRC AXI-Stream sources onto one master stream.
// Define AXIS_ARB_PACKET_LOCK_EN to hold each grant until the tlast beat (default: per-beat release).
module axis_rr_arbiter #(
  parameter int BUS_WIDTH = 16,
  parameter int NUM_SRC   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_aresetn,
  input  logic [NUM_SRC-1:0]             i_s_tvalid,
  input  logic [NUM_SRC*BUS_WIDTH-1:0]   i_s_tdata,
  input  logic [NUM_SRC-1:0]             i_s_tlast,
  output logic [NUM_SRC-1:0]             o_s_tready,
  output logic                           o_m_tvalid,
  input  logic                           i_m_tready,
  output logic [BUS_WIDTH-1:0]           o_m_tdata,
  output logic                           o_m_tlast,
  output logic [NUM_SRC-1:0]             o_grant,
  output logic                           o_busy
);

  // state | meaning
  // IDLE  | no grant held; next edge picks first requester at/after ptr
  // GRANT | source gidx_q owns the master stream until a releasing beat
  typedef enum logic {IDLE, GRANT} state_t;

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SRC - 1);

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     ptr_inc;
  logic [BUS_WIDTH-1:0] src_data [NUM_SRC];
  logic                 xfer;
  logic                 rel;

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      src_data[k] = i_s_tdata[k*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_SRC);
      if (i_s_tvalid[cand]) begin
        sel_idx = cand;
      end
    end
  end

  assign ptr_inc = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    o_m_tvalid = 1'b0;
    o_m_tdata  = '0;
    o_m_tlast  = 1'b0;
    o_s_tready = '0;
    o_busy     = 1'b0;
    xfer       = 1'b0;
    rel        = 1'b0;

    case (state_q)
      IDLE: begin
        if (|i_s_tvalid) begin
          state_d = GRANT;
          grant_d = ONE_HOT0 << sel_idx;
          gidx_d  = sel_idx;
        end
      end
      GRANT: begin
        o_busy             = 1'b1;
        o_m_tvalid         = i_s_tvalid[gidx_q];
        o_m_tdata          = src_data[gidx_q];
        o_m_tlast          = i_s_tlast[gidx_q];
        o_s_tready[gidx_q] = i_m_tready;
        xfer               = i_s_tvalid[gidx_q] & i_m_tready;
`ifdef AXIS_ARB_PACKET_LOCK_EN
        rel                = xfer & i_s_tlast[gidx_q];
`else
        rel                = xfer;
`endif
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_inc;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Reset is synchronous, so the outputs are masked until the edge lands.
    if (!i_aresetn) begin
      o_m_tvalid = 1'b0;
      o_m_tdata  = '0;
      o_m_tlast  = 1'b0;
      o_s_tready = '0;
      o_busy     = 1'b0;
    end
  end

  assign o_grant = grant_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed vector bench for axis_rr_arbiter (4 sources, 16-bit data).
// Packet-lock expectations follow AXIS_ARB_PACKET_LOCK_EN when it is defined.
module tb_axis_rr_arbiter;

  localparam int BW = 16;
  localparam int NS = 4;
  localparam logic [NS*BW-1:0] DATA = {16'h0D03, 16'h00A5, 16'h0B01, 16'h0A00};

  logic          clk = 1'b0;
  logic          rstn;
  logic [NS-1:0] s_tvalid;
  logic [NS*BW-1:0] s_tdata;
  logic [NS-1:0] s_tlast;
  logic [NS-1:0] s_tready;
  logic          m_tvalid;
  logic          m_tready;
  logic [BW-1:0] m_tdata;
  logic          m_tlast;
  logic [NS-1:0] grant;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.BUS_WIDTH(BW), .NUM_SRC(NS)) dut (
    .i_clk      (clk),
    .i_aresetn  (rstn),
    .i_s_tvalid (s_tvalid),
    .i_s_tdata  (s_tdata),
    .i_s_tlast  (s_tlast),
    .o_s_tready (s_tready),
    .o_m_tvalid (m_tvalid),
    .i_m_tready (m_tready),
    .o_m_tdata  (m_tdata),
    .o_m_tlast  (m_tlast),
    .o_grant    (grant),
    .o_busy     (busy)
  );

  typedef struct {
    logic          rstn;
    logic [NS-1:0] vld;
    logic          rdy;
    logic [NS-1:0] g;
    logic          busy;
    logic          mv;
    logic [BW-1:0] md;
    logic          ml;
    logic [NS-1:0] sr;
  } vec_t;

  vec_t tv [32];

  function automatic vec_t mk(input logic r, input logic [NS-1:0] v, input logic rd,
                              input logic [NS-1:0] g, input logic b, input logic mv,
                              input logic [BW-1:0] md, input logic [NS-1:0] sr);
    vec_t t;
    t.rstn = r;  t.vld = v;   t.rdy = rd; t.g  = g;  t.busy = b;
    t.mv   = mv; t.md  = md;  t.ml  = b;  t.sr = sr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NS-1:0] exp_g [$];
  int beats;

  initial begin
    rstn = 1'b0; s_tvalid = '0; s_tdata = DATA; s_tlast = '1; m_tready = 1'b0;
    tick(); tick();

    tv[0]  = mk(0, 4'b1111, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[1]  = mk(1, 4'b0100, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[2]  = mk(1, 4'b0100, 1, 4'b0100, 1, 1, 16'h00A5, 4'b0100);
    tv[3]  = mk(1, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[4]  = mk(1, 4'b1111, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[5]  = mk(1, 4'b1111, 1, 4'b1000, 1, 1, 16'h0D03, 4'b1000);
    tv[6]  = mk(1, 4'b1111, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[7]  = mk(1, 4'b1111, 1, 4'b0001, 1, 1, 16'h0A00, 4'b0001);
    tv[8]  = mk(1, 4'b1111, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[9]  = mk(1, 4'b1111, 1, 4'b0010, 1, 1, 16'h0B01, 4'b0010);
    tv[10] = mk(1, 4'b1111, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[11] = mk(1, 4'b1111, 1, 4'b0100, 1, 1, 16'h00A5, 4'b0100);
    tv[12] = mk(1, 4'b1111, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[13] = mk(1, 4'b1111, 1, 4'b1000, 1, 1, 16'h0D03, 4'b1000);
    tv[14] = mk(1, 4'b1111, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[15] = mk(1, 4'b1111, 1, 4'b0001, 1, 1, 16'h0A00, 4'b0001);
    tv[16] = mk(1, 4'b0010, 0, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    for (int i = 17; i <= 21; i++)
      tv[i] = mk(1, 4'b1011, 0, 4'b0010, 1, 1, 16'h0B01, 4'b0000);
    tv[22] = mk(1, 4'b1011, 1, 4'b0010, 1, 1, 16'h0B01, 4'b0010);
    tv[23] = mk(1, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[24] = mk(1, 4'b0001, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[25] = mk(1, 4'b0000, 1, 4'b0001, 1, 0, 16'h0A00, 4'b0001);
    tv[26] = mk(1, 4'b0001, 1, 4'b0001, 1, 1, 16'h0A00, 4'b0001);
    tv[27] = mk(1, 4'b0010, 0, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[28] = mk(1, 4'b0011, 0, 4'b0010, 1, 1, 16'h0B01, 4'b0000);
    tv[29] = mk(0, 4'b0011, 0, 4'b0010, 0, 0, 16'h0000, 4'b0000);
    tv[30] = mk(1, 4'b0011, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000);
    tv[31] = mk(1, 4'b0011, 1, 4'b0001, 1, 1, 16'h0A00, 4'b0001);

    for (int i = 0; i < 32; i++) begin
      rstn = tv[i].rstn; s_tvalid = tv[i].vld; m_tready = tv[i].rdy; s_tlast = '1;
      #3;
      check($sformatf("v%0d grant", i),  32'(grant),    32'(tv[i].g));
      check($sformatf("v%0d busy", i),   32'(busy),     32'(tv[i].busy));
      check($sformatf("v%0d mvalid", i), 32'(m_tvalid), 32'(tv[i].mv));
      check($sformatf("v%0d mdata", i),  32'(m_tdata),  32'(tv[i].md));
      check($sformatf("v%0d mlast", i),  32'(m_tlast),  32'(tv[i].ml));
      check($sformatf("v%0d sready", i), 32'(s_tready), 32'(tv[i].sr));
      tick();
    end

    // Source 0 streams a 3-beat packet while source 1 requests throughout.
    rstn = 1'b0; s_tvalid = '0; m_tready = 1'b1;
    tick();
    rstn = 1'b1;
`ifdef AXIS_ARB_PACKET_LOCK_EN
    exp_g = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
`else
    exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
`endif
    beats = 0;
    for (int c = 0; c < exp_g.size(); c++) begin
      s_tvalid = 4'b0011;
      s_tlast  = {3'b001, (beats == 2)};
      #3;
      check($sformatf("pkt c%0d grant", c), 32'(grant), 32'(exp_g[c]));
      if (exp_g[c] == 4'b0001) begin
        check($sformatf("pkt c%0d mlast", c), 32'(m_tlast), 32'(beats == 2));
        beats++;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 16, giving the tdata width in bits per stream.
REQ-002 The block SHALL have parameter NUM_SRC, default 4, giving the number of source streams (range 2..8).
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_aresetn, input, 1, reset, synchronous, active-low.
REQ-005 The block SHALL have port i_s_tvalid, input, NUM_SRC, with bit k the tvalid of source k.
REQ-006 The block SHALL have port i_s_tdata, input, NUM_SRC*BUS_WIDTH, with slice [k*BUS_WIDTH +: BUS_WIDTH] the tdata of source k.
REQ-007 The block SHALL have port i_s_tlast, input, NUM_SRC, with bit k the tlast of source k.
REQ-008 The block SHALL have port o_s_tready, output, NUM_SRC, with bit k the tready to source k.
REQ-009 The block SHALL have port o_m_tvalid, output, 1, the merged stream tvalid.
REQ-010 The block SHALL have port i_m_tready, input, 1, the merged stream tready from the downstream reader.
REQ-011 The block SHALL have port o_m_tdata, output, BUS_WIDTH, the merged stream tdata.
REQ-012 The block SHALL have port o_m_tlast, output, 1, the merged stream tlast.
REQ-013 The block SHALL have port o_grant, output, NUM_SRC, a one-hot grant vector that is all zeros when no grant is held.
REQ-014 The block SHALL have port o_busy, output, 1, which is high while in state GRANT.

Function
REQ-015 The block SHALL implement two states: IDLE and GRANT.
REQ-016 In IDLE, if any i_s_tvalid bit is high at a rising edge, the block SHALL select the first requesting source at or after pointer p (wrapping from NUM_SRC-1 to 0), load o_grant with that one-hot value, and enter GRANT.
REQ-017 In IDLE, o_m_tvalid SHALL be 0, o_s_tready SHALL be all zeros, and o_m_tdata/o_m_tlast SHALL be 0.
REQ-018 In GRANT with granted index g, o_m_tvalid SHALL equal i_s_tvalid[g], o_m_tdata SHALL equal source g's data, o_m_tlast SHALL equal i_s_tlast[g], o_s_tready[g] SHALL equal i_m_tready, and all other o_s_tready bits SHALL be 0 (combinational, zero latency).
REQ-019 A transfer SHALL be counted only on the cycle where i_s_tvalid[g] and i_m_tready are both high.
REQ-020 On a releasing transfer, at that edge the block SHALL return to IDLE, clear o_grant, and set p to (g+1) mod NUM_SRC.
REQ-021 Grant latency SHALL be exactly one cycle from IDLE with a valid request; there SHALL be exactly one idle cycle between consecutive grants.
REQ-022 In GRANT, no other source's tvalid SHALL affect the outputs or state, so the grant is not pre-empted.
REQ-023 If the granted source drops tvalid while in GRANT, the block SHALL remain in GRANT with o_m_tvalid low.
REQ-024 Simultaneous requests SHALL resolve strictly round-robin from p, so no source waits more than NUM_SRC-1 grants.

Reset
REQ-025 While i_aresetn is low at a rising edge, the block SHALL set state to IDLE, p to 0, and o_grant to 0.
REQ-026 While i_aresetn is low, the block SHALL hold o_busy, o_m_tvalid, o_m_tlast, o_m_tdata, and o_s_tready at 0.
REQ-027 A reset asserted mid-packet SHALL abandon the grant at that edge, with no partial-state carryover.

Configuration
REQ-028 With macro AXIS_ARB_PACKET_LOCK_EN defined, a releasing transfer SHALL be one with o_m_tlast high, so the grant holds for a whole packet.
REQ-029 With AXIS_ARB_PACKET_LOCK_EN undefined, every transfer SHALL be releasing (beat-level arbitration), and tlast SHALL still be forwarded but SHALL NOT affect state.

Verification
REQ-030 The bench SHALL cover this scenario: reset, then only source 2 valid with data 0x00A5 and tlast=1, and i_m_tready=1 -> o_grant=0100 one cycle after valid, o_m_tdata=0x00A5, o_s_tready=0100 for one cycle, then IDLE with p=3.
REQ-031 The bench SHALL cover this scenario: all four sources continuously valid with single-beat packets and i_m_tready=1 -> grant order 0,1,2,3,0, with one grant every 2 cycles.
REQ-032 The bench SHALL cover this scenario (PACKET_LOCK_EN): source 0 sends a 3-beat packet while source 1 is valid throughout -> o_grant stays 0001 for 3 beats, then 0010 after one idle cycle; without the macro, grants alternate 0,1,0,1 per beat.
REQ-033 The bench SHALL cover this scenario: i_m_tready=0 for 5 cycles during a grant -> o_m_tvalid high, o_m_tdata stable, o_s_tready=0000, grant held; the transfer completes on the first tready=1 cycle.
REQ-034 The bench SHALL cover this scenario: i_aresetn low for one cycle mid-packet (grant 0010) -> next cycle o_grant=0000, o_busy=0, and p=0, so source 0 wins the next simultaneous request from sources 0 and 1.
